c17_bist_ctrl: RTL and testbench
================================

C17_BIST_CTRL -- requirements
Module: c17_bist_ctrl

Interface
REQ-001 Parameter NUM_PATTERNS, default 31, is the number of patterns applied per run; the legal range is 1..31.
REQ-002 Parameter LFSR_SEED, default 5'b00001, is the first pattern applied; it SHALL be nonzero.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  run request, sampled only in IDLE or DONE.
REQ-006 gold_sig  input  8  expected MISR signature for the run.
REQ-007 pi  output  5  registered pattern driven to c17 N1,N2,N3,N6,N7 (bit0=N1 .. bit4=N7).
REQ-008 po  input  2  c17 responses: bit0=N22, bit1=N23.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  level, high while in DONE.
REQ-011 pass  output  1  registered compare result; valid while done=1.
REQ-012 sig  output  8  current MISR contents.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE, in a 2-bit encoding.
REQ-014 IDLE/DONE with start=1: next state RUN; pi<=LFSR_SEED, cnt<=1, sig<=8'h00, done<=0, pass<=0.
REQ-015 RUN, each edge: sig<=sig_next; if cnt==NUM_PATTERNS, go to DONE with pass<=(sig_next==gold_sig) and done<=1; otherwise pi<=lfsr_next(pi) and cnt<=cnt+1.
REQ-016 lfsr_next(q) = {q[3:0], q[4]^q[2]} (x^5+x^3+1, period 31); pi SHALL never be 0 during RUN.
REQ-017 sig_next = {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} XOR {6'b0, po}.
REQ-018 po is combinational from pi, so the po sampled on an edge SHALL belong to the pi registered on the previous edge.
REQ-019 Timing: if start is sampled at edge k, done SHALL rise at edge k+NUM_PATTERNS and busy SHALL be high for exactly NUM_PATTERNS cycles.
REQ-020 start during RUN SHALL be ignored; start held high in DONE SHALL restart a run.
REQ-021 In DONE, pi, sig, pass and done SHALL hold until start or rst.
REQ-022 cnt SHALL be 5 bits; with NUM_PATTERNS=31 there is no wrap, and the run ends on the 31st pattern.

Reset
REQ-023 On rst=1 at an edge: state=IDLE, pi=5'b0, cnt=0, sig=8'h00, busy=0, done=0, pass=0.
REQ-024 rst SHALL take priority over start and over any RUN activity, including mid-run; no partial result SHALL survive it.

Configuration
REQ-025 With macro C17_BIST_ABORT_EN defined, the block SHALL add an input port "abort" (1 bit); abort=1 in RUN moves the FSM to IDLE at the next edge with pi=0, sig held, done=0, pass=0.
REQ-026 abort SHALL have no effect in IDLE or DONE, and rst SHALL take priority over abort.
REQ-027 Without C17_BIST_ABORT_EN, the abort port and its logic SHALL be absent, and behaviour SHALL be as REQ-013..REQ-022.

Structure
REQ-028 Package c17_bist_pkg SHALL hold the state enum, PI_W=5, PO_W=2, SIG_W=8, the LFSR tap constant and the MISR tap constant.
REQ-029 The LFSR next-state function SHALL be the single sub-module bist_lfsr5 (combinational, pure function of q).
REQ-030 The MISR and the FSM SHALL live in c17_bist_ctrl; the c17 instance SHALL be external and connected by the bench or by the top level.

Verification
REQ-031 Reset: assert rst for 2 cycles -> pi=0, sig=8'h00, busy=0, done=0, pass=0.
REQ-032 NUM_PATTERNS=4, one start pulse -> pi=00001,00010,00100,01001 on successive cycles; busy high 4 cycles; done rises at edge k+4.
REQ-033 po forced 2'b00, gold_sig=8'h00 -> sig stays 8'h00 and pass=1; same run with gold_sig=8'h01 -> pass=0.
REQ-034 With real c17 connected and NUM_PATTERNS=31: sig matches the bench's reference-model signature; all 31 nonzero patterns appear exactly once.
REQ-035 start held high through RUN -> no restart; start=1 in DONE -> done=0 and pi=LFSR_SEED at the next edge.
REQ-036 rst asserted on the 3rd RUN cycle -> IDLE with all outputs zero at the next edge; with C17_BIST_ABORT_EN, abort on the 3rd RUN cycle -> IDLE, pi=0, done=0, sig held.

Source files
------------

// File: rtl/c17_bist_pkg.sv
// Shared definitions for the c17 BIST controller: widths, tap masks, FSM states.
package c17_bist_pkg;

  localparam int PI_W  = 5;
  localparam int PO_W  = 2;
  localparam int SIG_W = 8;

  // x^5 + x^3 + 1: feedback is q[4] ^ q[2]
  localparam logic [PI_W-1:0]  LFSR_TAPS = 5'b10100;

  // MISR feedback is sig[7] ^ sig[5] ^ sig[4] ^ sig[3]
  localparam logic [SIG_W-1:0] MISR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bist_lfsr5.sv
// Combinational next-state function of the 5-bit maximal-length pattern LFSR.
module bist_lfsr5
  import c17_bist_pkg::*;
(
  input  logic [PI_W-1:0] q,
  output logic [PI_W-1:0] q_next
);

  // Shift left and insert the parity of the tapped bits at bit 0
  assign q_next = {q[PI_W-2:0], ^(q & LFSR_TAPS)};

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for the ISCAS c17 circuit: LFSR pattern source, 8-bit MISR
// compactor and IDLE/RUN/DONE sequencing with a golden-signature compare.
// Optional feature: define C17_BIST_ABORT_EN to add an "abort" input that
// cancels a run in progress and returns to IDLE.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int              NUM_PATTERNS = 31,
  parameter logic [PI_W-1:0] LFSR_SEED    = 5'b00001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef C17_BIST_ABORT_EN
  input  logic             abort,
`endif
  input  logic [SIG_W-1:0] gold_sig,
  output logic [PI_W-1:0]  pi,
  input  logic [PO_W-1:0]  po,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig
);

  localparam logic [4:0] LAST_CNT = 5'(NUM_PATTERNS);

  state_t           state;
  state_t           state_next;
  logic [4:0]       cnt;
  logic [PI_W-1:0]  pi_next;
  logic [SIG_W-1:0] sig_next;
  logic             last_pattern;
  logic             abort_hit;

`ifdef C17_BIST_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  bist_lfsr5 u_lfsr (
    .q      (pi),
    .q_next (pi_next)
  );

  assign last_pattern = (cnt == LAST_CNT);

  // MISR step: shift in tap parity, then fold in the c17 responses of the current pattern
  always_comb begin
    sig_next = {sig[SIG_W-2:0], ^(sig & MISR_TAPS)} ^ {{(SIG_W-PO_W){1'b0}}, po};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: start is only honoured outside RUN; abort wins over the final pattern
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = RUN;
      RUN: begin
        if (abort_hit)         state_next = IDLE;
        else if (last_pattern) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decode directly from the registered state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: pattern register, pattern counter, MISR and the latched compare result
  always_ff @(posedge clk) begin
    if (rst) begin
      pi   <= '0;
      cnt  <= '0;
      sig  <= '0;
      pass <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pi   <= LFSR_SEED;
            cnt  <= 5'd1;
            sig  <= '0;
            pass <= 1'b0;
          end
        end
        RUN: begin
          if (abort_hit) begin
            pi   <= '0;
            cnt  <= '0;
            pass <= 1'b0;
          end else begin
            sig <= sig_next;
            if (last_pattern) begin
              pass <= (sig_next == gold_sig);
            end else begin
              pi  <= pi_next;
              cnt <= cnt + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Directed self-checking bench for c17_bist_ctrl: a 4-pattern instance with a
// bench-driven po, and a 31-pattern instance wired to a c17 model.
module tb_c17_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start31;
  logic [7:0] gold4, gold31;
  logic [1:0] po4, po31;
  logic [4:0] pi4, pi31;
  logic       busy4, busy31, done4, done31, pass4, pass31;
  logic [7:0] sig4, sig31;
`ifdef C17_BIST_ABORT_EN
  logic       abort4, abort31;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // c17: six NAND gates
  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    n1 = p[0]; n2 = p[1]; n3 = p[2]; n6 = p[3]; n7 = p[4];
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [4:0] lfsr_model(input logic [4:0] q);
    logic fb;
    fb = q[4] ^ q[2];
    return {q[3], q[2], q[1], q[0], fb};
  endfunction

  function automatic logic [7:0] misr_model(input logic [7:0] s, input logic [1:0] r);
    logic       fb;
    logic [7:0] t;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    t  = (s << 1) | {7'd0, fb};
    return t ^ {6'd0, r};
  endfunction

  assign po31 = c17(pi31);

  c17_bist_ctrl #(.NUM_PATTERNS(4), .LFSR_SEED(5'b00001)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .start    (start4),
`ifdef C17_BIST_ABORT_EN
    .abort    (abort4),
`endif
    .gold_sig (gold4),
    .pi       (pi4),
    .po       (po4),
    .busy     (busy4),
    .done     (done4),
    .pass     (pass4),
    .sig      (sig4)
  );

  c17_bist_ctrl #(.NUM_PATTERNS(31), .LFSR_SEED(5'b00001)) dut31 (
    .clk      (clk),
    .rst      (rst),
    .start    (start31),
`ifdef C17_BIST_ABORT_EN
    .abort    (abort31),
`endif
    .gold_sig (gold31),
    .pi       (pi31),
    .po       (po31),
    .busy     (busy31),
    .done     (done31),
    .pass     (pass31),
    .sig      (sig31)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Run dut4 from one start pulse until done, bounded
  task automatic run4(input string name);
    int n;
    start4 = 1'b1;
    cycle();
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      cycle();
      n++;
    end
    total++;
    if (done4 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_timeout done=%b required=1", name, done4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start4 = 1'b0; start31 = 1'b0;
    cycle();
    cycle();
    total++;
    if ({pi4, sig4, busy4, done4, pass4} !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset4 pi=%b sig=%h busy=%b done=%b pass=%b required all zero",
               pi4, sig4, busy4, done4, pass4);
    end
    total++;
    if ({pi31, sig31, busy31, done31, pass31} !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset31 pi=%b sig=%h busy=%b done=%b pass=%b required all zero",
               pi31, sig31, busy31, done31, pass31);
    end
    rst = 1'b0;
    cycle();
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_hold busy=%b done=%b required 0 0", busy4, done4);
    end
  endtask

  task automatic test_sequence();
    logic [4:0] exp_pi [4];
    int busy_cycles;
    exp_pi[0] = 5'b00001; exp_pi[1] = 5'b00010; exp_pi[2] = 5'b00100; exp_pi[3] = 5'b01001;
    po4 = 2'b00; gold4 = 8'h00;
    busy_cycles = 0;
    start4 = 1'b1;
    cycle();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cycle();
      if (busy4 === 1'b1) busy_cycles++;
      total++;
      if (pi4 !== exp_pi[i] || done4 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL seq_pi%0d pi=%b done=%b required pi=%b done=0", i, pi4, done4, exp_pi[i]);
      end
    end
    cycle();
    total++;
    if (done4 !== 1'b1 || busy4 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL seq_done_edge done=%b busy=%b required 1 0", done4, busy4);
    end
    total++;
    if (busy_cycles != 4) begin
      bad++;
      $display("[TB] FAIL seq_busy_len cycles=%0d required=4", busy_cycles);
    end
    total++;
    if (sig4 !== 8'h00 || pass4 !== 1'b1 || pi4 !== 5'b01001) begin
      bad++;
      $display("[TB] FAIL zero_po_pass sig=%h pass=%b pi=%b required sig=00 pass=1 pi=01001",
               sig4, pass4, pi4);
    end
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 3; i++) cycle();
    total++;
    if (done4 !== 1'b1 || pass4 !== 1'b1 || sig4 !== 8'h00 || pi4 !== 5'b01001 || busy4 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL done_hold done=%b pass=%b sig=%h pi=%b busy=%b required 1 1 00 01001 0",
               done4, pass4, sig4, pi4, busy4);
    end
  endtask

  task automatic test_bad_gold();
    po4 = 2'b00; gold4 = 8'h01;
    run4("bad_gold");
    total++;
    if (pass4 !== 1'b0 || sig4 !== 8'h00) begin
      bad++;
      $display("[TB] FAIL bad_gold pass=%b sig=%h required pass=0 sig=00", pass4, sig4);
    end
  endtask

  task automatic test_po_ones();
    // Constant po=01 over four steps: 01, 03, 07, 0F (no tap bits ever set)
    po4 = 2'b01; gold4 = 8'h0F;
    run4("po_ones");
    total++;
    if (sig4 !== 8'h0F || pass4 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL po_ones sig=%h pass=%b required sig=0f pass=1", sig4, pass4);
    end
  endtask

  task automatic test_start_held();
    logic [4:0] exp_pi [4];
    int n;
    exp_pi[0] = 5'b00001; exp_pi[1] = 5'b00010; exp_pi[2] = 5'b00100; exp_pi[3] = 5'b01001;
    po4 = 2'b00; gold4 = 8'h00;
    start4 = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cycle();
      total++;
      if (pi4 !== exp_pi[i] || busy4 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL held_norestart%0d pi=%b busy=%b required pi=%b busy=1", i, pi4, busy4, exp_pi[i]);
      end
    end
    cycle();
    total++;
    if (done4 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL held_done done=%b required=1", done4);
    end
    cycle();
    total++;
    if (done4 !== 1'b0 || pi4 !== 5'b00001 || busy4 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL held_restart done=%b pi=%b busy=%b required 0 00001 1", done4, pi4, busy4);
    end
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      cycle();
      n++;
    end
  endtask

  task automatic test_rst_mid_run();
    po4 = 2'b01;
    start4 = 1'b1;
    cycle();
    start4 = 1'b0;
    cycle();
    cycle();
    total++;
    if (sig4 !== 8'h03 || busy4 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrun_sig sig=%h busy=%b required sig=03 busy=1", sig4, busy4);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    total++;
    if ({pi4, sig4, busy4, done4, pass4} !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL rst_midrun pi=%b sig=%h busy=%b done=%b pass=%b required all zero",
               pi4, sig4, busy4, done4, pass4);
    end
    cycle();
    total++;
    if (busy4 !== 1'b0 || pi4 !== 5'b00000) begin
      bad++;
      $display("[TB] FAIL rst_stays_idle busy=%b pi=%b required 0 00000", busy4, pi4);
    end
  endtask

`ifdef C17_BIST_ABORT_EN
  task automatic test_abort();
    po4 = 2'b01;
    start4 = 1'b1;
    cycle();
    start4 = 1'b0;
    cycle();
    cycle();
    abort4 = 1'b1;
    cycle();
    total++;
    if (pi4 !== 5'b00000 || sig4 !== 8'h03 || done4 !== 1'b0 || busy4 !== 1'b0 || pass4 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort pi=%b sig=%h done=%b busy=%b pass=%b required 00000 03 0 0 0",
               pi4, sig4, done4, busy4, pass4);
    end
    cycle();
    abort4 = 1'b0;
    total++;
    if (busy4 !== 1'b0 || sig4 !== 8'h03) begin
      bad++;
      $display("[TB] FAIL abort_idle busy=%b sig=%h required 0 03", busy4, sig4);
    end
  endtask
`endif

  task automatic test_c17_full();
    logic [4:0] seq [31];
    logic [4:0] q;
    logic [7:0] ref_sig;
    int         seen [32];
    int         dup_err;
    q = 5'b00001;
    ref_sig = 8'h00;
    for (int i = 0; i < 31; i++) begin
      seq[i]  = q;
      ref_sig = misr_model(ref_sig, c17(q));
      q       = lfsr_model(q);
    end
    for (int v = 0; v < 32; v++) seen[v] = 0;
    gold31 = ref_sig;
    start31 = 1'b1;
    cycle();
    start31 = 1'b0;
    for (int i = 0; i < 31; i++) begin
      if (i > 0) cycle();
      seen[pi31]++;
      total++;
      if (pi31 !== seq[i] || busy31 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL c17_pi%0d pi=%b busy=%b required pi=%b busy=1", i, pi31, busy31, seq[i]);
      end
    end
    cycle();
    total++;
    if (done31 !== 1'b1 || sig31 !== ref_sig || pass31 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL c17_sig done=%b sig=%h pass=%b required done=1 sig=%h pass=1",
               done31, sig31, pass31, ref_sig);
    end
    dup_err = (seen[0] != 0) ? 1 : 0;
    for (int v = 1; v < 32; v++) if (seen[v] != 1) dup_err++;
    total++;
    if (dup_err != 0) begin
      bad++;
      $display("[TB] FAIL c17_coverage bad_slots=%0d required=0", dup_err);
    end
  endtask

  initial begin
    rst = 1'b1; start4 = 1'b0; start31 = 1'b0;
    gold4 = 8'h00; gold31 = 8'h00; po4 = 2'b00;
`ifdef C17_BIST_ABORT_EN
    abort4 = 1'b0; abort31 = 1'b0;
`endif
    #2;
    test_reset();
    test_sequence();
    test_done_hold();
    test_bad_gold();
    test_po_ones();
    test_start_held();
    test_rst_mid_run();
`ifdef C17_BIST_ABORT_EN
    test_abort();
`endif
    test_c17_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
